// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA package: master FSM states and AXI burst constants
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AR,
    ST_R,
    ST_DONE
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/dma_burst_calc.sv
// rtl/dma_burst_calc.sv - beats for the next burst: min(remaining words, max burst, words left in the 4 KB page)
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic [29:0] words,
  input  logic [9:0]  word_off,
  output logic [8:0]  beats
);

  localparam logic [8:0] MAX_B = 9'(MAX_BEATS);

  logic [10:0] to_4k;
  logic [8:0]  cand;

  // word_off is the word index inside the 4 KB page, so to_4k is always 1..1024
  always_comb begin
    to_4k = 11'(BOUNDARY_4K / 4) - {1'b0, word_off};
    cand  = (words < {21'd0, MAX_B}) ? words[8:0] : MAX_B;
    beats = ({2'b00, cand} > to_4k) ? to_4k[8:0] : cand;
  end

endmodule

// File: rtl/dma_read_master.sv
// rtl/dma_read_master.sv - AXI4 INCR read master streaming beats into the DMA FIFO; DMA_RD_ERR_CHECK_EN enables rresp/rlast error flag
module dma_read_master
  import dma_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [31:0]                   i_total_len,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
  output logic                          o_read_done,
  output logic                          o_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  dma_state_t  state, state_next;
  logic [AW-3:0] addr_w;
  logic [29:0] words;
  logic [8:0]  beats_q;
  logic [8:0]  cnt;
  logic [8:0]  calc_beats;
  logic        r_hs;

  dma_burst_calc #(.MAX_BEATS(C_M_AXI_BURST_LEN)) u_burst_calc (
    .words    (words),
    .word_off (addr_w[9:0]),
    .beats    (calc_beats)
  );

  assign r_hs          = m_axi_rvalid & m_axi_rready;
  assign o_fifo_wr_en  = r_hs;
  assign o_r_data      = m_axi_rdata;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    o_read_done   = 1'b0;
    case (state)
      ST_IDLE: if (i_start) state_next = ST_CALC;
      ST_CALC: state_next = (words == '0) ? ST_DONE : ST_AR;
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = ST_R;
      end
      ST_R: begin
        m_axi_rready = !i_fifo_full;
        // the beat counter, not rlast, closes the burst
        if (m_axi_rvalid && !i_fifo_full && cnt == 9'd1) state_next = ST_CALC;
      end
      ST_DONE: begin
        o_read_done = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_w       <= '0;
      words        <= '0;
      beats_q      <= '0;
      cnt          <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_start) begin
          addr_w <= i_src_addr[AW-1:2];
          words  <= i_total_len[31:2];
        end
        ST_CALC: if (words != '0) begin
          beats_q      <= calc_beats;
          m_axi_araddr <= {addr_w, 2'b00};
          m_axi_arlen  <= 8'(calc_beats - 9'd1);
        end
        ST_AR: if (m_axi_arready) begin
          addr_w <= addr_w + (AW-2)'(beats_q);
          words  <= words - {21'd0, beats_q};
          cnt    <= beats_q;
        end
        ST_R: if (r_hs) cnt <= cnt - 9'd1;
        default: ;
      endcase
    end
  end

`ifdef DMA_RD_ERR_CHECK_EN
  logic err_q;
  logic unused_bits;
  assign unused_bits = ^{i_src_addr[1:0], i_total_len[1:0], m_axi_rresp[0]};

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (state == ST_IDLE && i_start)
      err_q <= 1'b0;
    else if (state == ST_R && r_hs && (m_axi_rresp[1] || (m_axi_rlast != (cnt == 9'd1))))
      err_q <= 1'b1;
  end
  assign o_error = err_q;
`else
  logic unused_bits;
  assign unused_bits = ^{i_src_addr[1:0], i_total_len[1:0], m_axi_rresp, m_axi_rlast};
  assign o_error     = 1'b0;
`endif

endmodule
